// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative data cache.
//   fsm_state_t - miss-handling state machine encoding
//   set_of()    - set index of a byte address
//   tag_of()    - tag of a byte address
// Addresses are handled as 32-bit values; callers truncate to their widths.
package cache_pkg;

  localparam int unsigned BYTE_OFFSET = 2;

  typedef enum logic [1:0] {IDLE, FILL, RESPOND} fsm_state_t;

  function automatic logic [31:0] set_of(logic [31:0] addr, int unsigned set_w);
    return (addr >> BYTE_OFFSET) & ((32'd1 << set_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] addr, int unsigned set_w);
    return addr >> (BYTE_OFFSET + set_w);
  endfunction

endpackage

// File: rtl/cache_assoc_if.sv
// Pipeline-side request bus and data-memory fill handshake of the cache.
//   slave  - cache view: takes MemRead/WE/A/WD and fill data, drives RD/hit/stall/fill request
//   master - pipeline/memory view of the same signals
interface cache_assoc_if #(
  parameter int unsigned ADDRESS_WIDTH = 17,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     MemRead;
  logic [3:0]               WE;
  logic [ADDRESS_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0]    WD;
  logic [DATA_WIDTH-1:0]    RD;
  logic                     hit_o;
  logic                     stall_o;
  logic                     mem_req_o;
  logic [ADDRESS_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]    mem_rdata_i;
  logic                     mem_valid_i;

  modport slave (
    input  MemRead, WE, A, WD, mem_rdata_i, mem_valid_i,
    output RD, hit_o, stall_o, mem_req_o, mem_addr_o
  );

  modport master (
    output MemRead, WE, A, WD, mem_rdata_i, mem_valid_i,
    input  RD, hit_o, stall_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/cache_way.sv
// One way of the cache: valid/tag/data arrays, tag compare and byte-merge write.
//   clk, rst        - clock, async active-high reset (clears valid bits only)
//   rd_set, rd_tag  - combinational lookup; hit/valid/rdata reflect rd_set
//   wr_en, wr_set   - write strobe and target set
//   wr_fill         - line fill: also writes tag and sets valid
//   wr_be, wr_data  - byte enables and data merged into the line
module cache_way
  import cache_pkg::*;
#(
  parameter int unsigned TAG_WIDTH         = 12,
  parameter int unsigned SET_ADDRESS_WIDTH = 3,
  parameter int unsigned DATA_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SET_ADDRESS_WIDTH-1:0] rd_set,
  input  logic [TAG_WIDTH-1:0]         rd_tag,
  output logic                         hit,
  output logic                         valid,
  output logic [DATA_WIDTH-1:0]        rdata,
  input  logic                         wr_en,
  input  logic                         wr_fill,
  input  logic [SET_ADDRESS_WIDTH-1:0] wr_set,
  input  logic [TAG_WIDTH-1:0]         wr_tag,
  input  logic [3:0]                   wr_be,
  input  logic [DATA_WIDTH-1:0]        wr_data
);
  localparam int unsigned SETS = 1 << SET_ADDRESS_WIDTH;

  logic [SETS-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  assign valid = valid_q[rd_set];
  assign hit   = valid && (tag_q[rd_set] == rd_tag);
  assign rdata = data_q[rd_set];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_set] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_fill) tag_q[wr_set] <= wr_tag;
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_q[wr_set][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/cache_assoc.sv
// Set-associative, write-through, no-write-allocate data cache with LRU replacement.
//   CLK, RST                  - clock, async active-high reset
//   bus                       - request bus and fill handshake (cache_assoc_if.slave)
//   hit_count_o, miss_count_o - saturating counters: read+write hits, read misses
// Lookup is combinational in IDLE; a read miss stalls, fetches one word (FILL), fills the
// victim way, then presents the word for one RESPOND cycle.
module cache_assoc
  import cache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH     = 17,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned SET_ADDRESS_WIDTH = 3,
  parameter int unsigned WAYS              = 2,
  parameter int unsigned COUNT_WIDTH       = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  cache_assoc_if.slave           bus,
  output logic [COUNT_WIDTH-1:0] hit_count_o,
  output logic [COUNT_WIDTH-1:0] miss_count_o
);
  localparam int unsigned TAG_WIDTH = ADDRESS_WIDTH - SET_ADDRESS_WIDTH - BYTE_OFFSET;
  localparam int unsigned SETS      = 1 << SET_ADDRESS_WIDTH;

  fsm_state_t                   state_q;
  logic [TAG_WIDTH-1:0]         tag, tag_q;
  logic [SET_ADDRESS_WIDTH-1:0] set, set_q, wr_set;
  logic                         victim, victim_q, hit_way;
  logic [SETS-1:0]              lru_q;
  logic [DATA_WIDTH-1:0]        resp_q, hit_data, wr_data;
  logic [3:0]                   wr_be;
  logic                         mem_req_q;
  logic [ADDRESS_WIDTH-1:0]     mem_addr_q;
  logic [COUNT_WIDTH-1:0]       hit_cnt_q, miss_cnt_q;
  logic [WAYS-1:0]              way_hit, way_valid, way_wr;
  logic [DATA_WIDTH-1:0]        way_rdata [WAYS];
  logic                         idle, any_hit, is_write, rd_hit, wr_hit, rd_miss, fill_done;

  assign tag = TAG_WIDTH'(tag_of(32'(bus.A), SET_ADDRESS_WIDTH));
  assign set = SET_ADDRESS_WIDTH'(set_of(32'(bus.A), SET_ADDRESS_WIDTH));

  assign idle      = (state_q == IDLE);
  assign any_hit   = |way_hit;
  assign is_write  = |bus.WE;  // writes take priority over MemRead
  assign rd_hit    = idle && bus.MemRead && !is_write && any_hit;
  assign rd_miss   = idle && bus.MemRead && !is_write && !any_hit;
  assign wr_hit    = idle && is_write && any_hit;
  assign fill_done = (state_q == FILL) && bus.mem_valid_i;

  // The fill writes the latched set; a write hit writes the live request set.
  assign wr_set  = fill_done ? set_q : set;
  assign wr_be   = fill_done ? 4'hF : bus.WE;
  assign wr_data = fill_done ? bus.mem_rdata_i : bus.WD;

  always_comb begin
    hit_way  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (way_hit[w]) begin
        hit_way  = 1'(w);
        hit_data = way_rdata[w];
      end
    end
  end

  // Invalid ways are filled before the LRU way is evicted.
  if (WAYS == 1) begin : g_dm
    assign victim = 1'b0;
  end else begin : g_two_way
    assign victim = !way_valid[0] ? 1'b0 : !way_valid[1] ? 1'b1 : lru_q[set];
  end

  for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
    assign way_wr[w] = (wr_hit && way_hit[w]) || (fill_done && (victim_q == 1'(w)));

    cache_way #(
      .TAG_WIDTH        (TAG_WIDTH),
      .SET_ADDRESS_WIDTH(SET_ADDRESS_WIDTH),
      .DATA_WIDTH       (DATA_WIDTH)
    ) u_way (
      .clk    (CLK),
      .rst    (RST),
      .rd_set (set),
      .rd_tag (tag),
      .hit    (way_hit[w]),
      .valid  (way_valid[w]),
      .rdata  (way_rdata[w]),
      .wr_en  (way_wr[w]),
      .wr_fill(fill_done),
      .wr_set (wr_set),
      .wr_tag (tag_q),
      .wr_be  (wr_be),
      .wr_data(wr_data)
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      lru_q      <= '0;
      tag_q      <= '0;
      set_q      <= '0;
      victim_q   <= 1'b0;
      resp_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_hit || wr_hit) begin
            lru_q[set] <= !hit_way;
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
          end else if (rd_miss) begin
            tag_q      <= tag;
            set_q      <= set;
            victim_q   <= victim;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {tag, set, 2'b00};
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_valid_i) begin
            lru_q[set_q] <= !victim_q;
            resp_q       <= bus.mem_rdata_i;
            mem_req_q    <= 1'b0;
            state_q      <= RESPOND;
          end
        end
        RESPOND: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Combinational outputs are forced quiet while RST is held.
  assign bus.hit_o      = !RST && idle && any_hit;
  assign bus.stall_o    = !RST && (rd_miss || (state_q == FILL));
  assign bus.RD         = RST                    ? '0 :
                          (idle && any_hit)      ? hit_data :
                          (state_q == RESPOND)   ? resp_q : '0;
  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = mem_addr_q;
  assign hit_count_o    = hit_cnt_q;
  assign miss_count_o   = miss_cnt_q;

endmodule

// File: tb/tb_cache_assoc.sv
module tb_cache_assoc;
  import cache_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] hit_cnt, miss_cnt;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  cache_assoc_if #(.ADDRESS_WIDTH(17), .DATA_WIDTH(32)) bus_if ();

  cache_assoc #(
    .ADDRESS_WIDTH    (17),
    .DATA_WIDTH       (32),
    .SET_ADDRESS_WIDTH(3),
    .WAYS             (2),
    .COUNT_WIDTH      (4)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .bus         (bus_if),
    .hit_count_o (hit_cnt),
    .miss_count_o(miss_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input int exp_hit, input int exp_miss);
    check_eq({tag, " hit_count"}, 32'(hit_cnt), 32'(exp_hit));
    check_eq({tag, " miss_count"}, 32'(miss_cnt), 32'(exp_miss));
  endtask

  // Read that must hit in the same cycle.
  task automatic read_hit(input logic [16:0] addr, input logic [31:0] data);
    bus_if.MemRead = 1'b1;
    bus_if.WE      = 4'h0;
    bus_if.A       = addr;
    @(negedge clk);
    check_eq("rd_hit hit_o", 32'(bus_if.hit_o), 32'd1);
    check_eq("rd_hit RD", bus_if.RD, data);
    check_eq("rd_hit stall_o", 32'(bus_if.stall_o), 32'd0);
    next_cycle();
    bus_if.MemRead = 1'b0;
  endtask

  // Read miss; memory answers after nwait idle FILL cycles.
  task automatic read_miss(input logic [16:0] addr, input logic [31:0] data, input int nwait);
    bus_if.MemRead = 1'b1;
    bus_if.WE      = 4'h0;
    bus_if.A       = addr;
    @(negedge clk);
    check_eq("miss idle stall_o", 32'(bus_if.stall_o), 32'd1);
    check_eq("miss idle hit_o", 32'(bus_if.hit_o), 32'd0);
    check_eq("miss idle mem_req_o", 32'(bus_if.mem_req_o), 32'd0);
    next_cycle();
    for (int i = 0; i < nwait; i++) begin
      @(negedge clk);
      check_eq("fill mem_req_o", 32'(bus_if.mem_req_o), 32'd1);
      check_eq("fill mem_addr_o", 32'(bus_if.mem_addr_o), 32'(addr & 17'h1FFFC));
      check_eq("fill stall_o", 32'(bus_if.stall_o), 32'd1);
      next_cycle();
    end
    bus_if.mem_valid_i = 1'b1;
    bus_if.mem_rdata_i = data;
    @(negedge clk);
    check_eq("fill last stall_o", 32'(bus_if.stall_o), 32'd1);
    check_eq("fill last hit_o", 32'(bus_if.hit_o), 32'd0);
    next_cycle();
    bus_if.mem_valid_i = 1'b0;
    bus_if.mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk);
    check_eq("respond RD", bus_if.RD, data);
    check_eq("respond stall_o", 32'(bus_if.stall_o), 32'd0);
    check_eq("respond hit_o", 32'(bus_if.hit_o), 32'd0);
    check_eq("respond mem_req_o", 32'(bus_if.mem_req_o), 32'd0);
    next_cycle();
    bus_if.MemRead = 1'b0;
  endtask

  // Combinational lookup only; request is withdrawn before the next edge.
  task automatic probe(input logic [16:0] addr, input logic exp_hit);
    bus_if.MemRead = 1'b1;
    bus_if.WE      = 4'h0;
    bus_if.A       = addr;
    @(negedge clk);
    check_eq("probe hit_o", 32'(bus_if.hit_o), 32'(exp_hit));
    bus_if.MemRead = 1'b0;
    next_cycle();
  endtask

  initial begin
    rst                = 1'b1;
    bus_if.MemRead     = 1'b1;
    bus_if.WE          = 4'h0;
    bus_if.A           = 17'h00040;
    bus_if.WD          = '0;
    bus_if.mem_rdata_i = '0;
    bus_if.mem_valid_i = 1'b0;
    #2;
    check_eq("reset stall_o", 32'(bus_if.stall_o), 32'd0);
    check_eq("reset hit_o", 32'(bus_if.hit_o), 32'd0);
    check_eq("reset RD", bus_if.RD, 32'd0);
    check_eq("reset mem_req_o", 32'(bus_if.mem_req_o), 32'd0);
    check_eq("reset mem_addr_o", 32'(bus_if.mem_addr_o), 32'd0);
    check_counts("reset", 0, 0);
    next_cycle();
    next_cycle();
    rst            = 1'b0;
    bus_if.MemRead = 1'b0;

    // First miss, memory answers in the second FILL cycle.
    read_miss(17'h00040, 32'hDEADBEEF, 1);
    check_counts("first miss", 0, 1);
    read_hit(17'h00040, 32'hDEADBEEF);
    check_counts("first hit", 1, 1);

    // Two tags in set 0, then a third evicts the LRU one.
    read_miss(17'h00440, 32'hA5A50440, 0);
    read_hit(17'h00440, 32'hA5A50440);
    read_hit(17'h00040, 32'hDEADBEEF);
    check_counts("two ways", 3, 2);
    read_miss(17'h00840, 32'h0BAD0840, 2);
    probe(17'h00440, 1'b0);
    read_hit(17'h00040, 32'hDEADBEEF);
    read_miss(17'h00440, 32'hC0DE0440, 0);
    probe(17'h00840, 1'b0);
    read_hit(17'h00040, 32'hDEADBEEF);
    read_hit(17'h00440, 32'hC0DE0440);
    check_counts("eviction", 6, 4);

    // Write hit with MemRead also high: write wins, low two bytes merge.
    bus_if.MemRead = 1'b1;
    bus_if.WE      = 4'b0011;
    bus_if.WD      = 32'h12345678;
    bus_if.A       = 17'h00040;
    @(negedge clk);
    check_eq("wr_hit hit_o", 32'(bus_if.hit_o), 32'd1);
    check_eq("wr_hit stall_o", 32'(bus_if.stall_o), 32'd0);
    next_cycle();
    bus_if.WE = 4'h0;
    read_hit(17'h00040, 32'hDEAD5678);
    check_counts("write hit", 8, 4);

    // Write miss: no allocation, no stall, no counter change.
    bus_if.MemRead = 1'b1;
    bus_if.WE      = 4'hF;
    bus_if.WD      = 32'hFFFF0000;
    bus_if.A       = 17'h01000;
    @(negedge clk);
    check_eq("wr_miss stall_o", 32'(bus_if.stall_o), 32'd0);
    check_eq("wr_miss hit_o", 32'(bus_if.hit_o), 32'd0);
    check_eq("wr_miss mem_req_o", 32'(bus_if.mem_req_o), 32'd0);
    next_cycle();
    bus_if.WE      = 4'h0;
    bus_if.MemRead = 1'b0;
    check_counts("write miss", 8, 4);
    probe(17'h01000, 1'b0);
    read_hit(17'h00040, 32'hDEAD5678);

    // Reset in the middle of a fill.
    bus_if.MemRead = 1'b1;
    bus_if.A       = 17'h00080;
    next_cycle();
    @(negedge clk);
    check_eq("pre-abort mem_req_o", 32'(bus_if.mem_req_o), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort mem_req_o", 32'(bus_if.mem_req_o), 32'd0);
    check_eq("abort stall_o", 32'(bus_if.stall_o), 32'd0);
    check_eq("abort mem_addr_o", 32'(bus_if.mem_addr_o), 32'd0);
    check_counts("abort", 0, 0);
    next_cycle();
    rst            = 1'b0;
    bus_if.MemRead = 1'b0;
    read_miss(17'h00040, 32'h33334444, 0);
    check_counts("after reset", 0, 1);

    // Hit counter saturates at 15 in the 4-bit build.
    bus_if.MemRead = 1'b1;
    bus_if.A       = 17'h00040;
    for (int i = 1; i <= 17; i++) begin
      next_cycle();
      @(negedge clk);
      check_eq("sat hit_count", 32'(hit_cnt), (i > 15) ? 32'd15 : 32'(i));
    end
    bus_if.MemRead = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
